// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the APB4 round-robin arbiter.
// The APB_ARB_TIMEOUT_EN build option is consumed by apb_arb only.
package apb_arb_pkg;

    localparam int APB_DW = 32;
    localparam int APB_SW = 4;
    localparam int APB_PW = 3;
    // Widest address the captured request can carry; ADDR_W must not exceed it.
    localparam int APB_AW = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
        logic [APB_SW-1:0] strb;
        logic [APB_PW-1:0] prot;
    } apb_req_t;

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module apb_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            valid
);

    int          cand_s;
    logic [PW-1:0] cand_idx_s;

    // Scan requesters in priority order starting at ptr and keep the first hit
    always_comb begin
        gnt        = '0;
        gnt_idx    = '0;
        valid      = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s     = int'(ptr) + i;
            cand_s     = (cand_s >= NREQ) ? (cand_s - NREQ) : cand_s;
            cand_idx_s = PW'(cand_s);
            if (!valid && req[cand_idx_s]) begin
                valid           = 1'b1;
                gnt[cand_idx_s] = 1'b1;
                gnt_idx         = cand_idx_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/apb_arb.sv
// NREQ-port APB4 arbiter, round-robin, one downstream transfer per grant.
// Optional build macro APB_ARB_TIMEOUT_EN bounds the ACCESS phase to TIMEOUT_CYCLES.
module apb_arb
    import apb_arb_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic [NREQ-1:0]               s_psel,
    input  logic [NREQ-1:0]               s_penable,
    input  logic [NREQ-1:0]               s_pwrite,
    input  logic [NREQ-1:0][ADDR_W-1:0]   s_paddr,
    input  logic [NREQ-1:0][APB_DW-1:0]   s_pwdata,
    input  logic [NREQ-1:0][APB_SW-1:0]   s_pstrb,
    input  logic [NREQ-1:0][APB_PW-1:0]   s_pprot,
    output logic [NREQ-1:0]               s_pready,
    output logic [NREQ-1:0][APB_DW-1:0]   s_prdata,
    output logic [NREQ-1:0]               s_pslverr,
    output logic                          m_psel,
    output logic                          m_penable,
    output logic                          m_pwrite,
    output logic [ADDR_W-1:0]             m_paddr,
    output logic [APB_DW-1:0]             m_pwdata,
    output logic [APB_SW-1:0]             m_pstrb,
    output logic [APB_PW-1:0]             m_pprot,
    input  logic                          m_pready,
    input  logic [APB_DW-1:0]             m_prdata,
    input  logic                          m_pslverr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state_r;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   gnt_idx_r;
    logic [NREQ-1:0] gnt_oh_r;
    apb_req_t        req_r;
    logic            m_psel_r;
    logic            m_penable_r;

    logic [NREQ-1:0] pick_gnt_s;
    logic [PW-1:0]   pick_idx_s;
    logic            pick_valid_s;
    apb_req_t        req_s;
    logic [PW-1:0]   ptr_next_s;
    logic            timeout_s;
    logic            done_s;
    // Upstream PENABLE carries no information the arbiter needs.
    logic            unused_s;

    assign unused_s = ^s_penable;

    apb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req     (s_psel),
        .ptr     (ptr_r),
        .gnt     (pick_gnt_s),
        .gnt_idx (pick_idx_s),
        .valid   (pick_valid_s)
    );

    // Winning requester's transfer, strobes cleared for reads
    always_comb begin
        req_s       = '0;
        req_s.write = s_pwrite[pick_idx_s];
        req_s.addr  = APB_AW'(s_paddr[pick_idx_s]);
        req_s.wdata = s_pwdata[pick_idx_s];
        req_s.strb  = s_pwrite[pick_idx_s] ? s_pstrb[pick_idx_s] : {APB_SW{1'b0}};
        req_s.prot  = s_pprot[pick_idx_s];
    end

    assign ptr_next_s = (gnt_idx_r == PW'(NREQ - 1)) ? {PW{1'b0}} : (gnt_idx_r + PW'(1));

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_r;

    // Counts ACCESS cycles of the transfer in flight
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ARB_ACCESS) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    assign timeout_s = (state_r == ARB_ACCESS) && !m_pready &&
                       (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    assign done_s = (state_r == ARB_ACCESS) && (m_pready || timeout_s);

    // Arbitration FSM; downstream controls and payload come straight from flops
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r     <= ARB_IDLE;
            ptr_r       <= '0;
            gnt_idx_r   <= '0;
            gnt_oh_r    <= '0;
            req_r       <= '0;
            m_psel_r    <= 1'b0;
            m_penable_r <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_valid_s) begin
                        state_r     <= ARB_SETUP;
                        gnt_idx_r   <= pick_idx_s;
                        gnt_oh_r    <= pick_gnt_s;
                        req_r       <= req_s;
                        m_psel_r    <= 1'b1;
                        m_penable_r <= 1'b0;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_SETUP: begin
                    state_r     <= ARB_ACCESS;
                    m_penable_r <= 1'b1;
                end
                ARB_ACCESS: begin
                    if (done_s) begin
                        state_r     <= ARB_IDLE;
                        ptr_r       <= ptr_next_s;
                        gnt_oh_r    <= '0;
                        req_r       <= '0;
                        m_psel_r    <= 1'b0;
                        m_penable_r <= 1'b0;
                    end else begin
                        state_r <= ARB_ACCESS;
                    end
                end
                default: begin
                    state_r     <= ARB_IDLE;
                    gnt_oh_r    <= '0;
                    req_r       <= '0;
                    m_psel_r    <= 1'b0;
                    m_penable_r <= 1'b0;
                end
            endcase
        end
    end

    assign m_psel    = m_psel_r;
    assign m_penable = m_penable_r;
    assign m_pwrite  = req_r.write;
    assign m_paddr   = ADDR_W'(req_r.addr);
    assign m_pwdata  = req_r.wdata;
    assign m_pstrb   = req_r.strb;
    assign m_pprot   = req_r.prot;

    // Route the completion back to the granted requester only
    always_comb begin
        s_pready  = '0;
        s_prdata  = '0;
        s_pslverr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (done_s && gnt_oh_r[i]) begin
                s_pready[i]  = 1'b1;
                s_pslverr[i] = timeout_s | m_pslverr;
                s_prdata[i]  = (timeout_s || req_r.write) ? {APB_DW{1'b0}} : m_prdata;
            end else begin
                s_pready[i]  = 1'b0;
                s_pslverr[i] = 1'b0;
                s_prdata[i]  = {APB_DW{1'b0}};
            end
        end
    end

endmodule
